// File: rtl/mux_scan_pkg.sv
// Shared sizing, state encoding and sample payload for the mux channel scanner.
package mux_scan_pkg;

  localparam int unsigned N_CH    = 16;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned DW      = 2;
  localparam int unsigned DWELL_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [DW-1:0]    data;
  } sample_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

endpackage

// File: rtl/mux_scan_dwell.sv
// Loadable settle down-counter; expire is high once the count has reached zero.
module mux_scan_dwell
  import mux_scan_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequential scanner driving the 16:1 mux select and handing samples downstream.
// Optional MUX_SCAN_CHANGE_EN suppresses samples equal to the last reported value.
module mux_scan_ctrl
  import mux_scan_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [DW-1:0]      y,
  output logic [SEL_W-1:0]   cp,
  output logic               valid,
  input  logic               ready,
  output logic [DW-1:0]      data,
  output logic [SEL_W-1:0]   ch_out,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   insp_q, insp_d;
  logic [SEL_W-1:0]   cp_q, cp_d;
  logic               cont_q, cont_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  sample_t            smp_q, smp_d;
  logic               load_c, expire_c, skip_c, advance_c;

  mux_scan_dwell u_dwell (
    .clock  (clock),
    .reset  (reset),
    .load   (load_c),
    .value  (dwell_q),
    .expire (expire_c)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    insp_d    = insp_q;
    cp_d      = cp_q;
    cont_d    = cont_q;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    valid_d   = valid_q;
    smp_d     = smp_q;
    load_c    = 1'b0;
    advance_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          cont_d  = cont;
          mask_d  = ch_mask;
          dwell_d = dwell;
          idx_d   = '0;
          insp_d  = '0;
          state_d = ST_SEEK;
        end
      end
      ST_SEEK: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (mask_q[idx_q]) begin
          cp_d    = idx_q;
          load_c  = 1'b1;
          state_d = ST_SETTLE;
        end else begin
          idx_d  = idx_q + SEL_W'(1);
          insp_d = insp_q + SEL_W'(1);
          // A full lap of misses, or running off the top of a single pass, ends the scan.
          if (insp_q == LAST_CH || (!cont_q && idx_q == LAST_CH)) state_d = ST_FIN;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (expire_c) begin
          if (skip_c) begin
            advance_c = 1'b1;
          end else begin
            smp_d.ch   = cp_q;
            smp_d.data = y;
            valid_d    = 1'b1;
            state_d    = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        if (stop) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (ready) begin
          valid_d   = 1'b0;
          advance_c = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Move past the current channel, or close a single pass after the top channel.
    if (advance_c) begin
      if (cp_q == LAST_CH && !cont_q) begin
        state_d = ST_FIN;
      end else begin
        idx_d   = cp_q + SEL_W'(1);
        insp_d  = '0;
        state_d = ST_SEEK;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      insp_q  <= '0;
      cp_q    <= '0;
      cont_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      insp_q  <= insp_d;
      cp_q    <= cp_d;
      cont_q  <= cont_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      smp_q   <= smp_d;
    end
  end

`ifdef MUX_SCAN_CHANGE_EN
  logic [N_CH-1:0][DW-1:0] last_q, last_d;
  logic [N_CH-1:0]         rep_q, rep_d;

  assign skip_c = rep_q[cp_q] && (y == last_q[cp_q]);

  // Any completed transfer, including one coinciding with stop, updates the store.
  always_comb begin
    last_d = last_q;
    rep_d  = rep_q;
    if (valid_q && ready) begin
      last_d[smp_q.ch] = smp_q.data;
      rep_d[smp_q.ch]  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= '0;
      rep_q  <= '0;
    end else begin
      last_q <= last_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign skip_c = 1'b0;
`endif

  assign cp     = cp_q;
  assign valid  = valid_q;
  assign data   = smp_q.data;
  assign ch_out = smp_q.ch;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: directed scans with hand-computed transfers and timing.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, stop, cont, ready;
  logic [15:0] ch_mask;
  logic [7:0]  dwell;
  logic [1:0]  y, y_fix;
  logic        y_sel;
  logic [3:0]  cp, ch_out;
  logic [1:0]  data;
  logic        valid, busy, done;

  int total = 0;
  int bad = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  sample_t exp_q[$];

  always #5 clock = ~clock;

  assign y = y_sel ? y_fix : cp[1:0];

  mux_scan_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .cont(cont),
    .ch_mask(ch_mask), .dwell(dwell), .y(y), .cp(cp), .valid(valid),
    .ready(ready), .data(data), .ch_out(ch_out), .busy(busy), .done(done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input int ch, input int d);
    sample_t e;
    e.ch   = 4'(ch);
    e.data = 2'(d);
    exp_q.push_back(e);
  endtask

  // Pops the scoreboard on every accepted transfer, sampled mid-cycle.
  task automatic monitor();
    sample_t e;
    forever begin
      @(negedge clock);
      if (!reset && valid) valid_cyc++;
      if (!reset && done) done_cnt++;
      if (!reset && valid && ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL xfer_unexpected: got ch=%0d data=%0d expected none", ch_out, data);
        end else begin
          e = exp_q.pop_front();
          check("xfer_ch", 32'(ch_out), 32'(e.ch));
          check("xfer_data", 32'(data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ready = 1'b0;
    ch_mask = '0; dwell = '0; y_sel = 1'b0; y_fix = '0;
    @(negedge clock);
    reset = 1'b0;
    step(1);
  endtask

  task automatic go();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic run_until_done(input string nm, input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      step(1);
      cyc++;
    end
    check(nm, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string nm, input int budget, output int cyc);
    cyc = 0;
    while (!valid && cyc < budget) begin
      step(1);
      cyc++;
    end
    check(nm, 32'(valid), 32'd1);
  endtask

  task automatic wait_xfer(input string nm, input int target, input int budget);
    int i = 0;
    while (xfer_cnt < target && i < budget) begin
      step(1);
      i++;
    end
    check(nm, 32'(xfer_cnt), 32'(target));
  endtask

  initial begin
    int cyc, xb, db, vb;
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ready = 1'b0;
    ch_mask = '0; dwell = '0; y_sel = 1'b0; y_fix = '0;
    fork
      monitor();
    join_none

    // Reset state
    @(posedge clock);
    #1;
    check("rst_cp", 32'(cp), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Full single pass, dwell 0: 3 cycles per channel
    do_reset();
    ch_mask = 16'hFFFF; ready = 1'b1;
    for (int i = 0; i < 16; i++) push(i, i % 4);
    xb = xfer_cnt; db = done_cnt;
    go();
    run_until_done("t1_done_seen", 200, cyc);
    check("t1_cycles", 32'(cyc), 32'd48);
    step(1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_xfers", 32'(xfer_cnt - xb), 32'd16);
    check("t1_done_pulses", 32'(done_cnt - db), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Sparse mask 8001, dwell 3
    do_reset();
    ch_mask = 16'h8001; dwell = 8'd3; ready = 1'b1;
    push(0, 0); push(15, 3);
    xb = xfer_cnt;
    go();
    wait_valid("t2_valid_seen", 20, cyc);
    check("t2_cycles_to_valid", 32'(cyc), 32'd5);
    check("t2_cp0", 32'(cp), 32'd0);
    run_until_done("t2_done_seen", 100, cyc);
    check("t2_cycles_to_done", 32'(cyc + 5), 32'd26);
    step(1);
    check("t2_xfers", 32'(xfer_cnt - xb), 32'd2);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: ready low for 10 cycles while y moves
    do_reset();
    ch_mask = 16'h0010; y_sel = 1'b1; y_fix = 2'd1;
    push(4, 1);
    go();
    wait_valid("t3_valid_seen", 20, cyc);
    for (int k = 0; k < 10; k++) begin
      y_fix = 2'(2 + k % 2);
      step(1);
      check("t3_hold_valid", 32'(valid), 32'd1);
      check("t3_hold_data", 32'(data), 32'd1);
      check("t3_hold_ch", 32'(ch_out), 32'd4);
    end
    ready = 1'b1;
    step(1);
    check("t3_valid_drop", 32'(valid), 32'd0);
    run_until_done("t3_done_seen", 50, cyc);
    step(1);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Empty mask: 16 SEEK cycles + FIN
    do_reset();
    ready = 1'b1;
    db = done_cnt; vb = valid_cyc;
    go();
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step(1);
    end
    check("t4_busy_cycles", 32'(cyc), 32'd17);
    check("t4_done_pulses", 32'(done_cnt - db), 32'd1);
    check("t4_no_valid", 32'(valid_cyc - vb), 32'd0);

`ifndef MUX_SCAN_CHANGE_EN
    // Continuous 0,2,0,2,0 then stop inside SETTLE of channel 2
    do_reset();
    cont = 1'b1; ch_mask = 16'h0005; dwell = 8'd4; ready = 1'b1;
    push(0, 0); push(2, 2); push(0, 0); push(2, 2); push(0, 0);
    xb = xfer_cnt; db = done_cnt;
    go();
    wait_xfer("t5_xfers", xb + 5, 300);
    step(2);
    check("t5_settle_cp", 32'(cp), 32'd2);
    check("t5_settle_novalid", 32'(valid), 32'd0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t5_stop_busy", 32'(busy), 32'd0);
    check("t5_stop_valid", 32'(valid), 32'd0);
    step(10);
    check("t5_no_more_xfers", 32'(xfer_cnt - xb), 32'd5);
    check("t5_no_done", 32'(done_cnt - db), 32'd0);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    // Asynchronous reset while a sample is presented
    do_reset();
    cont = 1'b1; ch_mask = 16'h0006; y_sel = 1'b1; y_fix = 2'd3;
    go();
    wait_valid("t6_valid_seen", 20, cyc);
    check("t6_pre_ch", 32'(ch_out), 32'd1);
    check("t6_pre_data", 32'(data), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_arst_cp", 32'(cp), 32'd0);
    check("t6_arst_valid", 32'(valid), 32'd0);
    check("t6_arst_data", 32'(data), 32'd0);
    check("t6_arst_ch", 32'(ch_out), 32'd0);
    check("t6_arst_busy", 32'(busy), 32'd0);

`ifdef MUX_SCAN_CHANGE_EN
    // Change-only reporting with constant y
    do_reset();
    cont = 1'b1; ch_mask = 16'h0003; y_sel = 1'b1; y_fix = 2'd2; ready = 1'b1;
    push(0, 2); push(1, 2);
    xb = xfer_cnt;
    go();
    step(60);
    check("t7_first_lap", 32'(xfer_cnt - xb), 32'd2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t7_stopped", 32'(busy), 32'd0);
    y_fix = 2'd1;
    push(0, 1); push(1, 1);
    go();
    step(60);
    check("t7_after_change", 32'(xfer_cnt - xb), 32'd4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("t7_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
